// File: rtl/bp_write_scheduler_pkg.sv
// rtl/bp_write_scheduler_pkg.sv - shared buffer-control types and constants
package bp_write_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_SETTLE_W  = 3'd2,
        S_WAIT_IDLE = 3'd3,
        S_FINISH    = 3'd4
    } sched_state_t;

    // One BP beat is 32 bytes and a group is two lines, so bytes = beats << 6.
    localparam int BEAT_SHIFT = 6;

endpackage

// File: rtl/bp_write_scheduler.sv
// rtl/bp_write_scheduler.sv - splits a BP write job into per-group write-controller configurations
module bp_write_scheduler
    import bp_write_scheduler_pkg::*;
#(
    parameter int DDR_ADDR_LEN = 32,
    parameter int ADDR_LEN     = 16,
    parameter int SINGLE_LEN   = 24,
    parameter int GRP_LEN      = 8,
    parameter int SETTLE       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DDR_ADDR_LEN-1:0] job_ddr_addr,
    input  logic [ADDR_LEN-1:0]     job_bp_addr,
    input  logic [1:0]              job_bp_num,
    input  logic [SINGLE_LEN-1:0]   job_line_width,
    input  logic [GRP_LEN-1:0]      job_groups,
    input  logic                    wc_idle,
    output logic                    wc_conf,
    output logic [DDR_ADDR_LEN-1:0] wc_ddr_st_addr,
    output logic [SINGLE_LEN-1:0]   wc_data_ddr_byte,
    output logic [ADDR_LEN-1:0]     wc_BP_st_addr,
    output logic [1:0]              wc_BP_st_num,
    output logic [SINGLE_LEN-1:0]   wc_Line_width,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [GRP_LEN-1:0]      groups_done
);

    localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);

    sched_state_t              state;
    sched_state_t              state_nxt;
    logic [GRP_LEN-1:0]        groups_q;
    logic                      abort_q;
    logic [CNT_W-1:0]          settle_cnt;
    logic [GRP_LEN-1:0]        groups_done_inc;
    logic [DDR_ADDR_LEN-1:0]   ddr_step;
    logic                      job_empty;
    logic                      settle_done;
    logic                      finish_job;

    assign job_empty       = (job_groups == '0) || (job_line_width == '0);
    assign groups_done_inc = groups_done + 1'b1;
    assign finish_job      = (groups_done_inc == groups_q) || abort_q || abort;
    assign settle_done     = (settle_cnt == CNT_W'(SETTLE - 1));
    assign ddr_step        = DDR_ADDR_LEN'(wc_Line_width) << BEAT_SHIFT;

    always_comb begin
        state_nxt = state;
        wc_conf   = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) state_nxt = job_empty ? S_FINISH : S_ISSUE;
            end
            S_ISSUE: begin
                wc_conf   = 1'b1;
                state_nxt = (SETTLE == 0) ? S_WAIT_IDLE : S_SETTLE_W;
            end
            S_SETTLE_W: begin
                if (settle_done) state_nxt = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (wc_idle) state_nxt = finish_job ? S_FINISH : S_ISSUE;
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            groups_q         <= '0;
            abort_q          <= 1'b0;
            settle_cnt       <= '0;
            wc_ddr_st_addr   <= '0;
            wc_data_ddr_byte <= '0;
            wc_BP_st_addr    <= '0;
            wc_BP_st_num     <= '0;
            wc_Line_width    <= '0;
            aborted          <= 1'b0;
            groups_done      <= '0;
        end else begin
            state <= state_nxt;
            if (state != S_IDLE && abort) abort_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        groups_q    <= job_groups;
                        groups_done <= '0;
                        aborted     <= 1'b0;
                        abort_q     <= 1'b0;
                        // Empty jobs leave the controller-facing registers untouched.
                        if (!job_empty) begin
                            wc_ddr_st_addr   <= job_ddr_addr;
                            wc_BP_st_addr    <= job_bp_addr;
                            wc_BP_st_num     <= job_bp_num;
                            wc_Line_width    <= job_line_width;
                            wc_data_ddr_byte <= SINGLE_LEN'(job_line_width << BEAT_SHIFT);
                        end
                    end
                end
                S_ISSUE:    settle_cnt <= '0;
                S_SETTLE_W: settle_cnt <= settle_cnt + 1'b1;
                S_WAIT_IDLE: begin
                    if (wc_idle) begin
                        groups_done <= groups_done_inc;
                        if (finish_job) begin
                            aborted <= abort_q | abort;
                        end else begin
                            wc_ddr_st_addr <= wc_ddr_st_addr + ddr_step;
                            wc_BP_st_num   <= wc_BP_st_num + 2'd2;
                            // Banks 2/3 step past bank 3, so the next pair starts one line further on.
                            if (wc_BP_st_num[1])
                                wc_BP_st_addr <= wc_BP_st_addr + ADDR_LEN'(wc_Line_width);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bp_write_scheduler.md
BP_WRITE_SCHEDULER -- requirements
Module: bp_write_scheduler

Interface
REQ-001 SHALL have parameter DDR_ADDR_LEN, default 32: DDR byte-address width.
REQ-002 SHALL have parameter ADDR_LEN, default 16: BP buffer word-address width.
REQ-003 SHALL have parameter SINGLE_LEN, default 24: line-width and byte-length width.
REQ-004 SHALL have parameter GRP_LEN, default 8: group-count width.
REQ-005 SHALL have parameter SETTLE, default 2: cycles after wc_conf during which wc_idle is ignored.
REQ-006 SHALL have ports, one per line (name direction width meaning); one clock, reset synchronous active-high:
 clk  in  1  sole clock
 rst  in  1  synchronous active-high reset
 start  in  1  one-cycle job request
 abort  in  1  stop after current group
 job_ddr_addr  in  DDR_ADDR_LEN  DDR byte address of first group
 job_bp_addr  in  ADDR_LEN  BP start word address
 job_bp_num  in  2  first BP bank index
 job_line_width  in  SINGLE_LEN  beats per BP line
 job_groups  in  GRP_LEN  groups to write (one group = two BP lines)
 wc_idle  in  1  idle from the BP write controller
 wc_conf  out  1  one-cycle configure pulse to the BP write controller
 wc_ddr_st_addr  out  DDR_ADDR_LEN  group DDR address
 wc_data_ddr_byte  out  SINGLE_LEN  group byte length
 wc_BP_st_addr  out  ADDR_LEN  group BP address
 wc_BP_st_num  out  2  group first bank
 wc_Line_width  out  SINGLE_LEN  group line width
 busy  out  1  job in progress
 done  out  1  one-cycle completion pulse
 aborted  out  1  sticky: last job ended by abort
 groups_done  out  GRP_LEN  groups completed in current/last job

Function
REQ-007 SHALL implement states IDLE, ISSUE, SETTLE_W, WAIT_IDLE, FINISH.
REQ-008 IDLE: start=1 latches all job_* inputs, clears groups_done/aborted, goes ISSUE; start ignored in any other state.
REQ-009 start with job_groups=0 or job_line_width=0 SHALL go directly to FINISH (no wc_conf).
REQ-010 ISSUE: wc_conf=1 for exactly one cycle with wc_* driven from current-group registers; next state SETTLE_W.
REQ-011 wc_* data outputs SHALL be registered and stable from the wc_conf cycle until the next wc_conf.
REQ-012 SETTLE_W: count SETTLE cycles ignoring wc_idle, then WAIT_IDLE.
REQ-013 WAIT_IDLE: on wc_idle=1, groups_done+1; if groups_done+1==job_groups or abort seen, FINISH; else advance group, ISSUE.
REQ-014 Group advance: ddr_addr += line_width<<6 (DDR_ADDR_LEN wrap); bank += 2 (2-bit wrap); on bank wrap, bp_addr += line_width (ADDR_LEN truncation).
REQ-015 wc_data_ddr_byte SHALL equal line_width<<6 truncated to SINGLE_LEN (two lines x 32-byte beats).
REQ-016 abort SHALL be latched in any non-IDLE state; in-flight group SHALL complete; aborted=1 at FINISH; abort in IDLE ignored.
REQ-017 FINISH: done=1 one cycle, return IDLE; busy=1 in all states except IDLE.
REQ-018 start coincident with done cycle SHALL be ignored; start the following cycle SHALL be accepted.

Reset
REQ-019 rst=1 SHALL force IDLE and zero every output and internal register, including mid-job; no wc_conf or done after reset.
REQ-020 First start SHALL be accepted on the first cycle rst=0.

Structure
REQ-021 State encoding and bytes-per-beat shift (6) SHALL reside in the shared buffer-control package.
REQ-022 Single flat module; no sub-module.

Verification
REQ-023 job_groups=3, width=4, ddr=0x1000, bank=0, bp=0x10 -> wc_conf x3; ddr 0x1000/0x1100/0x1200, bank 0/2/0, bp 0x10/0x10/0x14, byte 256, done after 3rd idle.
REQ-024 job_groups=0 -> done 2 cycles after start, no wc_conf, groups_done=0.
REQ-025 wc_idle held 1 throughout -> still exactly SETTLE cycles between wc_conf and idle sampling.
REQ-026 abort during group 2 of 5 -> group 2 completes, done, aborted=1, groups_done=2.
REQ-027 rst mid WAIT_IDLE -> all outputs 0 next cycle; new job accepted immediately after.
REQ-028 start during busy and on done cycle -> ignored, latched job unchanged.
